// File: rtl/pg_prefix_adder_pipe.sv
// rtl/pg_prefix_adder_pipe.sv - 3-stage valid/ready Kogge-Stone prefix adder
// Optional signed-overflow output when ADDER_OVF_EN is defined.
module pg_prefix_adder_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             PAll
`ifdef ADDER_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int LEVELS = $clog2(WIDTH);

  logic             v1, v2;
  logic [WIDTH-1:0] p1, g1;
  logic             cin1;
  logic [WIDTH:0]   c2;
  logic [WIDTH-1:0] p2;
  logic             pall2;

  logic adv1, adv2, adv3, accept;

  assign adv3    = OutValid & OutReady;
  assign adv2    = v2 & (!OutValid | adv3);
  assign adv1    = v1 & (!v2 | adv2);
  assign InReady = !v1 | adv1;
  assign accept  = InValid & InReady;

  // Stage 1: per-bit propagate/generate cells.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      v1   <= 1'b0;
      p1   <= '0;
      g1   <= '0;
      cin1 <= 1'b0;
    end else begin
      if (accept) begin
        v1   <= 1'b1;
        p1   <= A ^ B;
        g1   <= A & B;
        cin1 <= Cin;
      end else if (adv1) begin
        v1 <= 1'b0;
      end
    end
  end

  logic [WIDTH-1:0] gk, pk, gn, pn;
  logic [WIDTH:0]   carry;

  // Kogge-Stone over bits 0..WIDTH-1; Cin is folded in afterwards through
  // the group propagate so the tree stays at ceil(log2(WIDTH)) levels.
  always_comb begin
    gk    = g1;
    pk    = p1;
    gn    = '0;
    pn    = '0;
    carry = '0;
    for (int l = 0; l < LEVELS; l++) begin
      gn = gk;
      pn = pk;
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= (1 << l)) begin
          gn[i] = gk[i] | (pk[i] & gk[i - (1 << l)]);
          pn[i] = pk[i] & pk[i - (1 << l)];
        end
      end
      gk = gn;
      pk = pn;
    end
    carry[0] = cin1;
    for (int i = 0; i < WIDTH; i++) begin
      carry[i+1] = gk[i] | (pk[i] & cin1);
    end
  end

  // Stage 2: carries, propagate and group propagate.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      v2    <= 1'b0;
      c2    <= '0;
      p2    <= '0;
      pall2 <= 1'b0;
    end else begin
      if (adv1) begin
        v2    <= 1'b1;
        c2    <= carry;
        p2    <= p1;
        pall2 <= &p1;
      end else if (adv2) begin
        v2 <= 1'b0;
      end
    end
  end

  // Stage 3: sum formation; outputs come straight from these registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      OutValid <= 1'b0;
      Sum      <= '0;
      Cout     <= 1'b0;
      PAll     <= 1'b0;
`ifdef ADDER_OVF_EN
      Ovf      <= 1'b0;
`endif
    end else begin
      if (adv2) begin
        OutValid <= 1'b1;
        Sum      <= p2 ^ c2[WIDTH-1:0];
        Cout     <= c2[WIDTH];
        PAll     <= pall2;
`ifdef ADDER_OVF_EN
        Ovf      <= c2[WIDTH] ^ c2[WIDTH-1];
`endif
      end else if (adv3) begin
        OutValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pg_prefix_adder_pipe.sv
// tb/tb_pg_prefix_adder_pipe.sv - directed bench for pg_prefix_adder_pipe
// Overflow checks are compiled in when ADDER_OVF_EN is defined.
module tb_pg_prefix_adder_pipe;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        InValid;
  logic        InReady;
  logic [15:0] A, B;
  logic        Cin;
  logic        OutValid;
  logic        OutReady;
  logic [15:0] Sum;
  logic        Cout;
  logic        PAll;
`ifdef ADDER_OVF_EN
  logic        Ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  pg_prefix_adder_pipe #(.WIDTH(16)) dut (
    .Clk(Clk), .Rst(Rst),
    .InValid(InValid), .InReady(InReady),
    .A(A), .B(B), .Cin(Cin),
    .OutValid(OutValid), .OutReady(OutReady),
    .Sum(Sum), .Cout(Cout), .PAll(PAll)
`ifdef ADDER_OVF_EN
    , .Ovf(Ovf)
`endif
  );

  logic [15:0] va [8] = '{16'h0001, 16'h1234, 16'hFFFF, 16'h8000, 16'h00FF, 16'hABCD, 16'hF0F0, 16'h7FFF};
  logic [15:0] vb [8] = '{16'h0002, 16'h4321, 16'hFFFF, 16'h8000, 16'h0001, 16'h1111, 16'h0F0F, 16'h0001};
  logic        vc [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [15:0] es [8] = '{16'h0003, 16'h5555, 16'hFFFF, 16'h0000, 16'h0100, 16'hBCDF, 16'hFFFF, 16'h8000};
  logic        ec [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic        ep [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`ifdef ADDER_OVF_EN
  logic        eo [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
`endif

  task automatic test_reset;
    Rst = 1'b1; InValid = 1'b0; OutReady = 1'b1; A = '0; B = '0; Cin = 1'b0;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    n_vec++; if (OutValid !== 1'b0) begin n_err++; $display("FAIL reset_outvalid got=%b exp=0", OutValid); end
    n_vec++; if (Sum !== 16'h0000) begin n_err++; $display("FAIL reset_sum got=%h exp=0000", Sum); end
    n_vec++; if ({Cout, PAll} !== 2'b00) begin n_err++; $display("FAIL reset_cout_pall got=%b exp=00", {Cout, PAll}); end
    n_vec++; if (InReady !== 1'b1) begin n_err++; $display("FAIL reset_inready got=%b exp=1", InReady); end
  endtask

  task automatic test_wrap;
    @(negedge Clk);
    A = 16'hFFFF; B = 16'h0001; Cin = 1'b0; InValid = 1'b1;
    @(negedge Clk);
    InValid = 1'b0;
    @(negedge Clk);
    n_vec++; if (OutValid !== 1'b0) begin n_err++; $display("FAIL wrap_early got=%b exp=0", OutValid); end
    @(negedge Clk);
    n_vec++; if (OutValid !== 1'b1) begin n_err++; $display("FAIL wrap_valid got=%b exp=1", OutValid); end
    n_vec++; if ({Cout, Sum, PAll} !== {1'b1, 16'h0000, 1'b0})
      begin n_err++; $display("FAIL wrap_result got=%b/%h/%b exp=1/0000/0", Cout, Sum, PAll); end
  endtask

  task automatic test_pall;
    @(negedge Clk);
    A = 16'hAAAA; B = 16'h5555; Cin = 1'b1; InValid = 1'b1;
    @(negedge Clk);
    Cin = 1'b0;
    @(negedge Clk);
    InValid = 1'b0;
    @(negedge Clk);
    n_vec++; if ({OutValid, Cout, Sum, PAll} !== {1'b1, 1'b1, 16'h0000, 1'b1})
      begin n_err++; $display("FAIL pall_cin1 got=%b/%b/%h/%b exp=1/1/0000/1", OutValid, Cout, Sum, PAll); end
    @(negedge Clk);
    n_vec++; if ({OutValid, Cout, Sum, PAll} !== {1'b1, 1'b0, 16'hFFFF, 1'b1})
      begin n_err++; $display("FAIL pall_cin0 got=%b/%b/%h/%b exp=1/0/ffff/1", OutValid, Cout, Sum, PAll); end
    @(negedge Clk);
  endtask

  task automatic test_back_to_back;
    OutReady = 1'b1;
    for (int k = 0; k < 11; k++) begin
      @(negedge Clk);
      if (k < 8) begin
        A = va[k]; B = vb[k]; Cin = vc[k]; InValid = 1'b1;
        n_vec++; if (InReady !== 1'b1) begin n_err++; $display("FAIL b2b_inready k=%0d got=%b exp=1", k, InReady); end
      end else begin
        InValid = 1'b0;
      end
      if (k == 2) begin
        n_vec++; if (OutValid !== 1'b0) begin n_err++; $display("FAIL b2b_early got=%b exp=0", OutValid); end
      end
      if (k >= 3) begin
        n_vec++;
        if ({OutValid, Cout, Sum, PAll} !== {1'b1, ec[k-3], es[k-3], ep[k-3]}) begin
          n_err++;
          $display("FAIL b2b_result idx=%0d got=%b/%b/%h/%b exp=1/%b/%h/%b",
                   k-3, OutValid, Cout, Sum, PAll, ec[k-3], es[k-3], ep[k-3]);
        end
`ifdef ADDER_OVF_EN
        n_vec++; if (Ovf !== eo[k-3]) begin n_err++; $display("FAIL b2b_ovf idx=%0d got=%b exp=%b", k-3, Ovf, eo[k-3]); end
`endif
      end
    end
    @(negedge Clk);
    n_vec++; if (OutValid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got=%b exp=0", OutValid); end
  endtask

  task automatic test_backpressure;
    int acc = 0;
    OutReady = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge Clk);
      A = va[3+(acc%3)]; B = vb[3+(acc%3)]; Cin = vc[3+(acc%3)]; InValid = 1'b1;
      n_vec++; if (InReady !== (j < 3)) begin n_err++; $display("FAIL bp_inready cyc=%0d got=%b exp=%b", j, InReady, (j < 3)); end
      if (InReady) acc++;
      if (j >= 3) begin
        n_vec++;
        if ({OutValid, Cout, Sum} !== {1'b1, ec[3], es[3]})
          begin n_err++; $display("FAIL bp_hold cyc=%0d got=%b/%b/%h exp=1/%b/%h", j, OutValid, Cout, Sum, ec[3], es[3]); end
      end
    end
    for (int r = 0; r < 4; r++) begin
      @(negedge Clk);
      OutReady = 1'b1; InValid = 1'b0;
      if (r < 3) begin
        n_vec++;
        if ({OutValid, Cout, Sum, PAll} !== {1'b1, ec[3+r], es[3+r], ep[3+r]})
          begin n_err++; $display("FAIL bp_release idx=%0d got=%b/%b/%h/%b exp=1/%b/%h/%b",
                                  r, OutValid, Cout, Sum, PAll, ec[3+r], es[3+r], ep[3+r]); end
      end else begin
        n_vec++; if (OutValid !== 1'b0) begin n_err++; $display("FAIL bp_extra got=%b exp=0", OutValid); end
      end
    end
  endtask

  task automatic test_mid_reset;
    OutReady = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge Clk);
      A = va[j]; B = vb[j]; Cin = vc[j]; InValid = 1'b1;
    end
    @(negedge Clk);
    InValid = 1'b0; Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    n_vec++; if (OutValid !== 1'b0) begin n_err++; $display("FAIL rst_outvalid got=%b exp=0", OutValid); end
    n_vec++; if ({Cout, Sum} !== 17'h0) begin n_err++; $display("FAIL rst_sum got=%b/%h exp=0/0000", Cout, Sum); end
    n_vec++; if (InReady !== 1'b1) begin n_err++; $display("FAIL rst_inready got=%b exp=1", InReady); end
    OutReady = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge Clk);
      n_vec++; if (OutValid !== 1'b0) begin n_err++; $display("FAIL rst_stale cyc=%0d got=%b exp=0", j, OutValid); end
    end
  endtask

`ifdef ADDER_OVF_EN
  task automatic test_ovf;
    logic [15:0] oa [3] = '{16'h7FFF, 16'h8000, 16'h0001};
    logic [15:0] ob [3] = '{16'h0001, 16'hFFFF, 16'h0001};
    logic [15:0] os [3] = '{16'h8000, 16'h7FFF, 16'h0002};
    logic        oc [3] = '{1'b0, 1'b1, 1'b0};
    logic        oo [3] = '{1'b1, 1'b1, 1'b0};
    OutReady = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge Clk);
      if (k < 3) begin A = oa[k]; B = ob[k]; Cin = 1'b0; InValid = 1'b1; end
      else InValid = 1'b0;
      if (k >= 3) begin
        n_vec++;
        if ({OutValid, Ovf, Cout, Sum} !== {1'b1, oo[k-3], oc[k-3], os[k-3]})
          begin n_err++; $display("FAIL ovf idx=%0d got=%b/%b/%b/%h exp=1/%b/%b/%h",
                                  k-3, OutValid, Ovf, Cout, Sum, oo[k-3], oc[k-3], os[k-3]); end
      end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_wrap;
    test_pall;
    test_back_to_back;
    test_backpressure;
    test_mid_reset;
`ifdef ADDER_OVF_EN
    test_ovf;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
